stream_gen_p: RTL and testbench
===============================

Name: stream_gen_p

Overview:
- Parametrised successor to the byte-wide stream source: a DATA_W-wide, DEPTH-entry buffer filled by edge-detected push strobes and drained as one AXI-Stream packet per op_en request.
- Adds compile-time FIFO/LIFO ordering, full AXI handshake compliance (beat held until tready), true DEPTH capacity, a fixed packet length latched at packet start, and a sticky overflow/drop flag.
- Sits between testbench or register stimulus and an AXI-Stream consumer such as the I2C master's TX path.

Parameters:
- DATA_W, 8, tdata/din width in bits.
- DEPTH, 16, buffer entries; any value ≥2, not restricted to a power of two.
- LIFO, 0, ordering: 0 = first-in-first-out, 1 = last-in-first-out.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  DATA_W  write data
- push  in  1  write strobe; one entry written per rising edge of push
- op_en  in  1  drain request (level)
- clr_ovf  in  1  synchronous clear of overflow
- tdata  out  DATA_W  stream data
- tvalid  out  1  stream valid
- tready  in  1  stream ready
- tlast  out  1  final beat of packet
- buff_count  out  CNT_W  current occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: a push was discarded

Behaviour:
- Reset (async, rst_n=0): count=0, pointers=0, state=IDLE, tdata=0, tvalid=0, tlast=0, overflow=0, push_q=0, empty=1, full=0. Takes effect immediately, including mid-packet; the packet is abandoned and the buffer discarded.
- Push detection: push_q registers push. A write event occurs on the clock edge where push=1 and push_q=0. A level held high writes once.
- Write: if not full, store din and increment count on the same edge. If full, discard and set overflow.
- FIFO mode: separate wr_ptr and rd_ptr, each wrapping explicitly DEPTH-1 → 0.
- LIFO mode: write at index count; read from index count-1.
- buff_count, empty and full decode the count register combinationally, so they have zero lag versus count.
- State IDLE:
  - tvalid=0.
  - On an edge with op_en=1 and count>0: latch pkt_left=count, load the first entry into tdata, set tvalid=1, set tlast=(count==1), decrement count, and enter DRAIN.
  - The first beat is visible the cycle after op_en is sampled.
- State DRAIN:
  - tdata, tvalid and tlast are held stable while tready=0.
  - On an edge with tvalid&tready and pkt_left>1: pop the next entry into tdata, decrement pkt_left and count, and set tlast=(pkt_left==2).
  - On an edge with tvalid&tready and pkt_left==1: set tvalid=0, tlast=0, and return to IDLE.
  - A new packet can start no earlier than one cycle later, with one idle cycle between packets.
- op_en deasserting mid-packet has no effect: the packet always completes and tvalid never drops before the handshake.
- Push during DRAIN, FIFO mode:
  - Accepted if not full.
  - Not part of the current packet, since pkt_left is fixed.
  - A simultaneous push and pop leaves count unchanged; full is evaluated on the pre-edge count.
- Push during DRAIN, LIFO mode: always discarded and overflow set, because it would corrupt the stack order.
- overflow clears on clr_ovf=1. If a discard happens on the same edge as clr_ovf, set wins.
- Arithmetic: count and pkt_left are CNT_W unsigned and never wrap, guaranteed by the guards above.

Decomposition:
- stream_gen_pkg holds:
  - the state enum (IDLE, DRAIN);
  - the mode constants MODE_FIFO=0 and MODE_LIFO=1;
  - a function returning the next pointer with DEPTH wrap.
- Sub-module stream_buf holds storage, pointers and count with push/pop/full/empty. stream_gen_p holds edge detect, the FSM, the output register and the flags.

Test Plan:
- FIFO, DEPTH=16: push 0x11,0x22,0x33, pulse op_en, tready=1 → beats 0x11,0x22,0x33 on consecutive cycles; tlast only on 0x33; count 3→0; empty=1 after.
- LIFO=1: same pushes → 0x33,0x22,0x11; tlast on 0x11; a push during DRAIN → dropped, overflow=1; clr_ovf → overflow=0.
- Backpressure: 4 entries, tready low for 5 cycles after first tvalid → tdata/tvalid/tlast stable throughout; 4 handshakes total; no beat lost or duplicated.
- Capacity, DEPTH=5: 5 pushes → full=1, buff_count=5; 6th push → ignored, overflow=1; a held push level → exactly one write.
- FIFO concurrent: 8 entries draining, push 0xAA mid-packet → packet is 8 beats with tlast on 8th; afterwards count=1; next op_en → single beat 0xAA with tlast=1.
- Reset mid-packet: rst_n low during beat 3 of 6 → tvalid=0, tlast=0, count=0, empty=1 asynchronously; after release, op_en → no packet.

Source files
------------

// File: rtl/stream_gen_pkg.sv
// Shared types and helpers for the parametrised stream source.
package stream_gen_pkg;

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam bit MODE_FIFO = 1'b0;
  localparam bit MODE_LIFO = 1'b1;

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic int next_ptr(int ptr, int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_gen_p_if.sv
// AXI-Stream beat bus between the stream source and its consumer.
interface stream_gen_p_if #(parameter int DATA_W = 8) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/stream_buf.sv
// Storage, ordering and occupancy for the stream source; callers guard push/pop.
module stream_buf
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter bit LIFO   = MODE_FIFO,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  wr_idx, rd_idx;

  generate
    if (LIFO == MODE_LIFO) begin : g_lifo
      // Stack: top of stack is always entry count-1.
      assign wr_idx = PTR_W'(cnt_q);
      assign rd_idx = (cnt_q == '0) ? '0 : PTR_W'(cnt_q - CNT_W'(1));
    end else begin : g_fifo
      logic [PTR_W-1:0] wr_ptr, rd_ptr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (wr_en) wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
          if (rd_en) rd_ptr <= PTR_W'(next_ptr(32'(rd_ptr), DEPTH));
        end
      end
      assign wr_idx = wr_ptr;
      assign rd_idx = rd_ptr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else begin
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = cnt_q;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/stream_gen_p.sv
// Buffered AXI-Stream source: edge-detected pushes, one packet drained per op_en.
module stream_gen_p
  import stream_gen_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter bit LIFO   = MODE_FIFO,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              push,
  input  logic              op_en,
  input  logic              clr_ovf,
  stream_gen_p_if.master    axis,
  output logic [CNT_W-1:0]  buff_count,
  output logic              empty,
  output logic              full,
  output logic              overflow
);
  state_t            state;
  logic              push_q;
  logic [CNT_W-1:0]  pkt_left;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              push_evt, start, pop_hs, lifo_block, discard, wr_en, rd_en;

  assign push_evt = push & ~push_q;
  assign start    = (state == IDLE) && op_en && !empty;
  assign pop_hs   = (state == DRAIN) && axis.tvalid && axis.tready && (pkt_left > CNT_W'(1));
  assign rd_en    = start | pop_hs;
  // A stack cannot take a write while it is being popped without losing order.
  assign lifo_block = (LIFO == MODE_LIFO) && ((state == DRAIN) || start);
  assign discard  = push_evt && (full || lifo_block);
  assign wr_en    = push_evt && !discard;

  stream_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LIFO(LIFO), .CNT_W(CNT_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign buff_count = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      push_q <= push;
      if (discard)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pkt_left    <= '0;
      axis.tdata  <= '0;
      axis.tvalid <= 1'b0;
      axis.tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          axis.tvalid <= 1'b0;
          axis.tlast  <= 1'b0;
          if (start) begin
            pkt_left    <= count;
            axis.tdata  <= rd_data;
            axis.tvalid <= 1'b1;
            axis.tlast  <= (count == CNT_W'(1));
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (axis.tvalid && axis.tready) begin
            if (pkt_left > CNT_W'(1)) begin
              axis.tdata <= rd_data;
              pkt_left   <= pkt_left - CNT_W'(1);
              axis.tlast <= (pkt_left == CNT_W'(2));
            end else begin
              axis.tvalid <= 1'b0;
              axis.tlast  <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_gen_p.sv
// Directed bench: FIFO/16, LIFO/16 and FIFO/5 instances share one stimulus bus.
module tb_stream_gen_p;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       push = 1'b0, op_en = 1'b0, clr_ovf = 1'b0, tready = 1'b0;

  logic [4:0] cnt_f, cnt_l;
  logic [2:0] cnt_c;
  logic       emp_f, emp_l, emp_c, ful_f, ful_l, ful_c, ovf_f, ovf_l, ovf_c;

  int n_cmp = 0;
  int n_err = 0;

  stream_gen_p_if #(.DATA_W(8)) if_f ();
  stream_gen_p_if #(.DATA_W(8)) if_l ();
  stream_gen_p_if #(.DATA_W(8)) if_c ();
  assign if_f.tready = tready;
  assign if_l.tready = tready;
  assign if_c.tready = tready;

  always #5 clk = ~clk;

  stream_gen_p #(.DATA_W(8), .DEPTH(16), .LIFO(1'b0)) u_fifo (
    .clk(clk), .rst_n(rst_n), .din(din), .push(push), .op_en(op_en), .clr_ovf(clr_ovf),
    .axis(if_f), .buff_count(cnt_f), .empty(emp_f), .full(ful_f), .overflow(ovf_f));
  stream_gen_p #(.DATA_W(8), .DEPTH(16), .LIFO(1'b1)) u_lifo (
    .clk(clk), .rst_n(rst_n), .din(din), .push(push), .op_en(op_en), .clr_ovf(clr_ovf),
    .axis(if_l), .buff_count(cnt_l), .empty(emp_l), .full(ful_l), .overflow(ovf_l));
  stream_gen_p #(.DATA_W(8), .DEPTH(5), .LIFO(1'b0)) u_cap (
    .clk(clk), .rst_n(rst_n), .din(din), .push(push), .op_en(op_en), .clr_ovf(clr_ovf),
    .axis(if_c), .buff_count(cnt_c), .empty(emp_c), .full(ful_c), .overflow(ovf_c));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; din = '0; push = 1'b0; op_en = 1'b0; clr_ovf = 1'b0; tready = 1'b0;
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic push_byte(input logic [7:0] d);
    din = d; push = 1'b1; tick();
    push = 1'b0; tick();
  endtask

  task automatic start_pkt();
    op_en = 1'b1; tick();
    op_en = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; #2;
    n_cmp++;
    if ({if_f.tvalid, if_f.tlast, if_f.tdata, cnt_f, emp_f, ful_f, ovf_f} !== {2'b00, 8'h00, 5'd0, 3'b100}) begin
      n_err++;
      $display("FAIL reset: got tv=%b tl=%b td=%h cnt=%0d e=%b f=%b o=%b, want 0 0 00 0 1 0 0",
               if_f.tvalid, if_f.tlast, if_f.tdata, cnt_f, emp_f, ful_f, ovf_f);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fifo();
    logic [7:0] exp_d [3];
    logic [4:0] exp_c [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    exp_c[0] = 5'd2;  exp_c[1] = 5'd1;  exp_c[2] = 5'd0;
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    n_cmp++;
    if (cnt_f !== 5'd3) begin n_err++; $display("FAIL fifo_cnt3: got %0d want 3", cnt_f); end
    tready = 1'b1;
    start_pkt();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({if_f.tvalid, if_f.tdata, if_f.tlast, cnt_f} !== {1'b1, exp_d[i], (i == 2), exp_c[i]}) begin
        n_err++;
        $display("FAIL fifo_beat%0d: got v=%b d=%h l=%b c=%0d want v=1 d=%h l=%b c=%0d",
                 i, if_f.tvalid, if_f.tdata, if_f.tlast, cnt_f, exp_d[i], (i == 2), exp_c[i]);
      end
      tick();
    end
    n_cmp++;
    if ({if_f.tvalid, if_f.tlast, emp_f} !== 3'b001) begin
      n_err++; $display("FAIL fifo_end: got v=%b l=%b e=%b want 0 0 1", if_f.tvalid, if_f.tlast, emp_f);
    end
    tready = 1'b0;
  endtask

  task automatic test_lifo();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h33; exp_d[1] = 8'h22; exp_d[2] = 8'h11;
    do_reset();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    start_pkt();
    din = 8'h44; push = 1'b1; tick();
    push = 1'b0; tick();
    n_cmp++;
    if ({ovf_l, cnt_l, if_l.tvalid, if_l.tdata} !== {1'b1, 5'd2, 1'b1, 8'h33}) begin
      n_err++;
      $display("FAIL lifo_drop: got o=%b c=%0d v=%b d=%h want 1 2 1 33", ovf_l, cnt_l, if_l.tvalid, if_l.tdata);
    end
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({if_l.tvalid, if_l.tdata, if_l.tlast} !== {1'b1, exp_d[i], (i == 2)}) begin
        n_err++;
        $display("FAIL lifo_beat%0d: got v=%b d=%h l=%b want 1 %h %b",
                 i, if_l.tvalid, if_l.tdata, if_l.tlast, exp_d[i], (i == 2));
      end
      tick();
    end
    tready = 1'b0;
    n_cmp++;
    if ({if_l.tvalid, emp_l, ovf_l} !== 3'b011) begin
      n_err++; $display("FAIL lifo_end: got v=%b e=%b o=%b want 0 1 1", if_l.tvalid, emp_l, ovf_l);
    end
    clr_ovf = 1'b1; tick();
    clr_ovf = 1'b0;
    n_cmp++;
    if (ovf_l !== 1'b0) begin n_err++; $display("FAIL lifo_clr: got o=%b want 0", ovf_l); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    int hs;
    exp_d[0] = 8'hA1; exp_d[1] = 8'hA2; exp_d[2] = 8'hA3; exp_d[3] = 8'hA4;
    do_reset();
    for (int i = 0; i < 4; i++) push_byte(exp_d[i]);
    start_pkt();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({if_f.tvalid, if_f.tdata, if_f.tlast} !== {1'b1, 8'hA1, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want 1 a1 0", i, if_f.tvalid, if_f.tdata, if_f.tlast);
      end
      tick();
    end
    tready = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (if_f.tvalid) begin
        n_cmp++;
        if (hs > 3 || if_f.tdata !== exp_d[hs & 3] || if_f.tlast !== (hs == 3)) begin
          n_err++;
          $display("FAIL bp_beat%0d: got d=%h l=%b want %h %b", hs, if_f.tdata, if_f.tlast, exp_d[hs & 3], (hs == 3));
        end
        hs++;
      end
      tick();
    end
    tready = 1'b0;
    n_cmp++;
    if (hs !== 4) begin n_err++; $display("FAIL bp_count: got %0d handshakes want 4", hs); end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
    n_cmp++;
    if ({ful_c, cnt_c, ovf_c} !== {1'b1, 3'd5, 1'b0}) begin
      n_err++; $display("FAIL cap_full: got f=%b c=%0d o=%b want 1 5 0", ful_c, cnt_c, ovf_c);
    end
    push_byte(8'h99);
    n_cmp++;
    if ({ful_c, cnt_c, ovf_c} !== {1'b1, 3'd5, 1'b1}) begin
      n_err++; $display("FAIL cap_ovf: got f=%b c=%0d o=%b want 1 5 1", ful_c, cnt_c, ovf_c);
    end
    do_reset();
    din = 8'h5A; push = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    push = 1'b0; tick();
    n_cmp++;
    if (cnt_c !== 3'd1) begin n_err++; $display("FAIL cap_level: got c=%0d want 1", cnt_c); end
  endtask

  task automatic test_concurrent();
    do_reset();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    tready = 1'b1;
    start_pkt();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({if_f.tvalid, if_f.tdata, if_f.tlast} !== {1'b1, 8'(i + 1), (i == 7)}) begin
        n_err++;
        $display("FAIL conc_beat%0d: got v=%b d=%h l=%b want 1 %h %b",
                 i, if_f.tvalid, if_f.tdata, if_f.tlast, 8'(i + 1), (i == 7));
      end
      din = 8'hAA; push = (i == 2);
      tick();
    end
    push = 1'b0;
    n_cmp++;
    if ({if_f.tvalid, cnt_f} !== {1'b0, 5'd1}) begin
      n_err++; $display("FAIL conc_after: got v=%b c=%0d want 0 1", if_f.tvalid, cnt_f);
    end
    start_pkt();
    n_cmp++;
    if ({if_f.tvalid, if_f.tdata, if_f.tlast} !== {1'b1, 8'hAA, 1'b1}) begin
      n_err++; $display("FAIL conc_aa: got v=%b d=%h l=%b want 1 aa 1", if_f.tvalid, if_f.tdata, if_f.tlast);
    end
    tick();
    tready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) push_byte(8'(8'hC0 + i));
    tready = 1'b1;
    start_pkt();
    tick(); tick();
    n_cmp++;
    if (if_f.tdata !== 8'hC2) begin n_err++; $display("FAIL rmid_beat3: got d=%h want c2", if_f.tdata); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_f.tvalid, if_f.tlast, cnt_f, emp_f} !== {2'b00, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rmid_async: got v=%b l=%b c=%0d e=%b want 0 0 0 1", if_f.tvalid, if_f.tlast, cnt_f, emp_f);
    end
    #2 rst_n = 1'b1;
    tick();
    op_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({if_f.tvalid, cnt_f} !== {1'b0, 5'd0}) begin
        n_err++; $display("FAIL rmid_nopkt%0d: got v=%b c=%0d want 0 0", i, if_f.tvalid, cnt_f);
      end
    end
    op_en = 1'b0; tready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fifo();
    test_lifo();
    test_backpressure();
    test_capacity();
    test_concurrent();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
